// File: rtl/pwm_cfg_scheduler_pkg.sv
// rtl/pwm_cfg_scheduler_pkg.sv - shared constants, FSM encoding and command layout for the PWM config scheduler
// Package pwm_sched_pkg:
//   FUNC_CONFIG / FUNC_ENABLE : accepted packet function codes
//   sched_state_t             : scheduler FSM encoding
//   cmd_t                     : 88-bit queued command {func, pkt_data}
package pwm_sched_pkg;

   localparam logic [7:0] FUNC_CONFIG = 8'h01;
   localparam logic [7:0] FUNC_ENABLE = 8'h02;
   localparam int         CMD_W       = 88;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      STOP  = 3'd2,
      WAIT  = 3'd3,
      WRITE = 3'd4,
      ARM   = 3'd5
   } sched_state_t;

   // Field order mirrors pkt_data: rev_data1 (channel) is the most significant byte.
   typedef struct packed {
      logic [7:0]  func;
      logic [7:0]  ch;         // rev_data1
      logic [7:0]  ctrl;       // rev_data2
      logic [7:0]  duty;       // rev_data3
      logic [15:0] dessert;    // rev_data4..5
      logic [7:0]  pulse_num;  // rev_data6
      logic [31:0] pat;        // rev_data7..10
   } cmd_t;

endpackage

// File: rtl/pwm_cfg_scheduler_if.sv
// rtl/pwm_cfg_scheduler_if.sv - packet input, channel-side and status signals of the PWM config scheduler
// Interface pwm_cfg_scheduler_if #(NUM_CH):
//   packet   : pack_done, func_reg[7:0], pkt_data[79:0]
//   channels : ch_busy[NUM_CH], ch_en[NUM_CH], cfg_we[NUM_CH], cfg_duty, cfg_dessert, cfg_pulse_num, cfg_pat
//   status   : cmd_full, drop_cnt[7:0], err_range, err_timeout, sched_busy
// Modports: slave = scheduler, master = decoder / channel array side.
interface pwm_cfg_scheduler_if #(
   parameter int NUM_CH = 4
);
   logic              pack_done;
   logic [7:0]        func_reg;
   logic [79:0]       pkt_data;
   logic [NUM_CH-1:0] ch_busy;
   logic [NUM_CH-1:0] ch_en;
   logic [NUM_CH-1:0] cfg_we;
   logic [7:0]        cfg_duty;
   logic [15:0]       cfg_dessert;
   logic [7:0]        cfg_pulse_num;
   logic [31:0]       cfg_pat;
   logic              cmd_full;
   logic [7:0]        drop_cnt;
   logic              err_range;
   logic              err_timeout;
   logic              sched_busy;

   modport slave (
      input  pack_done, func_reg, pkt_data, ch_busy,
      output ch_en, cfg_we, cfg_duty, cfg_dessert, cfg_pulse_num, cfg_pat,
             cmd_full, drop_cnt, err_range, err_timeout, sched_busy
   );

   modport master (
      output pack_done, func_reg, pkt_data, ch_busy,
      input  ch_en, cfg_we, cfg_duty, cfg_dessert, cfg_pulse_num, cfg_pat,
             cmd_full, drop_cnt, err_range, err_timeout, sched_busy
   );
endinterface

// File: rtl/pwm_cmd_fifo.sv
// rtl/pwm_cmd_fifo.sv - synchronous command FIFO with registered read and drop-when-full push
// Ports:
//   clk_50M, rst_n         : clock, synchronous active-low reset
//   push, push_data[W]     : write request; ignored when full (full judged before any same-cycle pop)
//   pop, pop_data[W]       : read request; pop_data is registered and holds until the next pop
//   full, empty            : occupancy flags
module pwm_cmd_fifo #(
   parameter int DEPTH = 4,   // power of 2, at least 2
   parameter int W     = 88
) (
   input  logic         clk_50M,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push, do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk_50M) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         pop_data <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop) begin
            pop_data <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/pwm_cfg_scheduler.sv
// rtl/pwm_cfg_scheduler.sv - queues decoded PWM config packets and commits them only to stopped, idle channels
// Ports:
//   clk_50M, rst_n : clock, synchronous active-low reset
//   bus (slave)    : packet input, per-channel busy/enable/write strobe and cfg data, status flags
// Optional build macro PWM_SCHED_TIMEOUT_EN: bounds the busy wait to TIMEOUT_CYC cycles and
// reports a forced write on err_timeout; without it the wait is unbounded and err_timeout is 0.
module pwm_cfg_scheduler
   import pwm_sched_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic clk_50M,
   input  logic rst_n,
   pwm_cfg_scheduler_if.slave bus
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   sched_state_t      state, next_state;
   logic [CMD_W-1:0]  fifo_dout;
   cmd_t              cmd_q;
   logic              fifo_full, fifo_empty, fifo_pop;
   logic              code_ok, in_range, push_req;
   logic [CH_W-1:0]   ch_sel;
   logic [NUM_CH-1:0] ch_mask;
   logic              busy_sel, timeout_hit;

   logic [NUM_CH-1:0] ch_en_q, cfg_we_q;
   logic [7:0]        duty_q, pulse_num_q, drop_cnt_q;
   logic [15:0]       dessert_q;
   logic [31:0]       pat_q;
   logic              err_range_q;

   assign code_ok  = (bus.func_reg == FUNC_CONFIG) || (bus.func_reg == FUNC_ENABLE);
   assign in_range = int'(bus.pkt_data[79:72]) < NUM_CH;
   assign push_req = bus.pack_done && code_ok && in_range;

   pwm_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(CMD_W)) u_fifo (
      .clk_50M   (clk_50M),
      .rst_n     (rst_n),
      .push      (push_req),
      .push_data ({bus.func_reg, bus.pkt_data}),
      .pop       (fifo_pop),
      .pop_data  (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // The FIFO's registered read port doubles as the holding register: it only
   // changes on a pop, and pops happen only in IDLE.
   assign cmd_q    = cmd_t'(fifo_dout);
   assign ch_sel   = cmd_q.ch[CH_W-1:0];
   assign ch_mask  = NUM_CH'(1) << ch_sel;
   assign busy_sel = bus.ch_busy[ch_sel];

   logic unused_cmd_bits;
   assign unused_cmd_bits = ^{cmd_q.ch[7:CH_W], cmd_q.ctrl[7:1]};

   always_ff @(posedge clk_50M) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      fifo_pop   = 1'b0;
      case (state)
         IDLE:  if (!fifo_empty) begin
                   fifo_pop   = 1'b1;
                   next_state = FETCH;
                end
         FETCH: next_state = (cmd_q.func == FUNC_ENABLE) ? ARM : STOP;
         STOP:  next_state = WAIT;
         WAIT:  if (!busy_sel || timeout_hit) next_state = WRITE;
         WRITE: next_state = ARM;
         ARM:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

`ifdef PWM_SCHED_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [TO_W-1:0] wait_cnt;
   logic            err_timeout_q;

   assign timeout_hit = (wait_cnt == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk_50M) begin
      if (!rst_n || state != WAIT) wait_cnt <= '0;
      else                         wait_cnt <= wait_cnt + TO_W'(1);
   end

   always_ff @(posedge clk_50M) begin
      if (!rst_n)                                       err_timeout_q <= 1'b0;
      else if (state == WAIT && busy_sel && timeout_hit) err_timeout_q <= 1'b1;
   end

   assign bus.err_timeout = err_timeout_q;
`else
   assign timeout_hit     = 1'b0;
   assign bus.err_timeout = 1'b0;
`endif

   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         ch_en_q     <= '0;
         cfg_we_q    <= '0;
         duty_q      <= '0;
         dessert_q   <= '0;
         pulse_num_q <= '0;
         pat_q       <= '0;
         drop_cnt_q  <= '0;
         err_range_q <= 1'b0;
      end else begin
         // Strobe and data are registered on entry to WRITE, so both are visible
         // in the WRITE cycle; the data then holds until the next commit.
         cfg_we_q <= '0;
         if (next_state == WRITE) begin
            cfg_we_q    <= ch_mask;
            duty_q      <= cmd_q.duty;
            dessert_q   <= cmd_q.dessert;
            pulse_num_q <= cmd_q.pulse_num;
            pat_q       <= cmd_q.pat;
         end

         // A CONFIG re-arm lands on the same edge that closes the write strobe,
         // so the channel restarts the cycle right after its parameters commit.
         case (state)
            STOP:  ch_en_q[ch_sel] <= 1'b0;
            WRITE: ch_en_q[ch_sel] <= cmd_q.ctrl[0];
            ARM:   if (cmd_q.func == FUNC_ENABLE) ch_en_q[ch_sel] <= cmd_q.ctrl[0];
            default: ;
         endcase

         if (bus.pack_done && code_ok && !in_range) err_range_q <= 1'b1;
         if (push_req && fifo_full && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
   end

   assign bus.ch_en         = ch_en_q;
   assign bus.cfg_we        = cfg_we_q;
   assign bus.cfg_duty      = duty_q;
   assign bus.cfg_dessert   = dessert_q;
   assign bus.cfg_pulse_num = pulse_num_q;
   assign bus.cfg_pat       = pat_q;
   assign bus.cmd_full      = fifo_full;
   assign bus.drop_cnt      = drop_cnt_q;
   assign bus.err_range     = err_range_q;
   assign bus.sched_busy    = (state != IDLE) || !fifo_empty;
endmodule

// File: doc/pwm_cfg_scheduler.md
# pwm_cfg_scheduler

Sequences UART-decoded configuration commands into the pattern-PWM channels, so a channel's parameters never change while its pulse train is active. It sits between the UART packet decoder and the `pattern_pwm` channel array, replacing direct register writes. Packets are buffered in a small command FIFO. A state machine then stops the target channel, waits for it to go idle, commits the new parameters with a one-cycle write strobe, and re-arms the channel.

## Interface
- `NUM_CH`, 4 — number of PWM channels served.
- `FIFO_DEPTH`, 4 — command FIFO entries; must be a power of 2.
- `TIMEOUT_CYC`, 1024 — maximum cycles spent waiting for channel busy to drop.

Ports:
- `clk_50M`  in  1  — sole clock.
- `rst_n`  in  1  — synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `pack_done`  in  1  — one-cycle pulse: packet valid.
- `func_reg`  in  8  — packet function code.
- `pkt_data`  in  80  — {rev_data1 … rev_data10}; rev_data1 (channel) is in [79:72].
- `ch_busy`  in  NUM_CH  — per-channel busy from `pattern_pwm`.
- `ch_en`  out  NUM_CH  — per-channel enable level.
- `cfg_we`  out  NUM_CH  — one-hot, one-cycle parameter write strobe.
- `cfg_duty`  out  8  — duty_num to commit.
- `cfg_dessert`  out  16  — pulse_dessert to commit.
- `cfg_pulse_num`  out  8  — pulse_num to commit.
- `cfg_pat`  out  32  — PAT to commit.
- `cmd_full`  out  1  — FIFO full.
- `drop_cnt`  out  8  — saturating count of dropped packets.
- `err_range`  out  1  — sticky flag: channel index ≥ NUM_CH seen.
- `err_timeout`  out  1  — sticky flag: forced write after timeout.
- `sched_busy`  out  1  — FSM not in IDLE, or FIFO not empty.

## Operation
- **Accepted codes:**
  - 0x01 CONFIG: ctrl = rev_data2, duty = rev_data3, dessert = {rev_data4, rev_data5}, pulse_num = rev_data6, PAT = {rev_data7..rev_data10}.
  - 0x02 ENABLE: ch_en[ch] ← rev_data2[0].
  - Any other code is ignored silently. It is not counted as a drop.
- **Enqueue on pack_done:**
  - If ch ≥ NUM_CH: drop the packet and set err_range.
  - Else if FIFO is full: drop the packet and increment drop_cnt; it saturates at 0xFF.
  - Fullness is judged on the pre-pop count. A push arriving in the same cycle as a pop while full is still dropped.
- **FSM states:** IDLE, FETCH, STOP, WAIT, WRITE, ARM.
  - IDLE → FETCH when the FIFO is not empty; pop the head entry into a holding register.
  - FETCH → ARM for code 0x02. ARM sets ch_en[ch] = rev_data2[0].
  - FETCH → STOP for code 0x01. STOP drives ch_en[ch] ← 0.
  - STOP → WAIT.
  - WAIT → WRITE when ch_busy[ch] == 0, or when the timeout expires (see Configuration).
  - WRITE asserts cfg_we[ch] for exactly one cycle. cfg_* data is valid in that same cycle and holds until the next WRITE.
  - WRITE → ARM. ARM sets ch_en[ch] ← ctrl[0], then returns to IDLE.
- Channels other than ch keep their ch_en unchanged throughout.
- Commands are processed strictly in FIFO order. There is no per-channel reordering.

## Timing
- **Reset values:**
  - ch_en = 0, cfg_we = 0, cfg_* = 0.
  - cmd_full = 0, drop_cnt = 0, err_range = 0, err_timeout = 0, sched_busy = 0.
  - FIFO empty, FSM in IDLE.
- **CONFIG latency** (idle channel, empty FIFO, pack_done high in cycle 0):
  - ch_en[ch] falls in cycle 3.
  - cfg_we[ch] is high in cycle 4.
  - ch_en[ch] = ctrl[0] from cycle 5.
- **ENABLE latency:** ch_en[ch] changes in cycle 3.
- Back-to-back commands: the next FETCH follows ARM → IDLE → FETCH, so the minimum command spacing is 3 cycles (ENABLE) or 6 cycles (CONFIG).
- Reset asserted mid-operation clears everything on the next edge. Any in-flight write is abandoned and no cfg_we is issued.
- A pack_done arriving during WRITE/ARM is enqueued normally.

## Configuration
- **`PWM_SCHED_TIMEOUT_EN` defined:** WAIT counts cycles from 0. On reaching TIMEOUT_CYC−1 with busy still high, the FSM forces WRITE and sets err_timeout.
- **Not defined:** WAIT blocks indefinitely until busy drops. err_timeout is tied to 0 and the counter is not synthesized.

## Structure
- **Package `pwm_sched_pkg`:**
  - Function-code constants FUNC_CONFIG = 8'h01 and FUNC_ENABLE = 8'h02.
  - FSM state encoding.
  - Command entry width of 88 bits: {func, pkt_data}.
- **Sub-module `pwm_cmd_fifo`:** synchronous FIFO with registered read, full/empty flags, and a push-drop-when-full policy. The scheduler FSM is kept in the top level.

## Test plan
- **Basic CONFIG:** ch_busy = 0; send 0x01, ch = 2, ctrl = 0x01, duty = 0x10, dessert = 0x0032, pulse_num = 3, PAT = 0x00FFFFFF. Expect cfg_we = 4'b0100 in cycle 4 with those values, and ch_en[2] = 1 from cycle 5.
- **Busy wait:** hold ch_busy[1] = 1 for 20 cycles after STOP. cfg_we[1] must not assert until the cycle after busy drops; err_timeout stays 0.
- **Timeout** (macro on, TIMEOUT_CYC = 16): keep ch_busy[0] = 1 permanently. Expect a forced cfg_we[0] after 16 WAIT cycles and err_timeout = 1.
- **Overflow:** stall the FSM on a busy channel and send 6 CONFIG packets. Expect 1 in flight plus 4 queued, cmd_full = 1, and drop_cnt = 1. Queued commands must then drain in order.
- **Range and ENABLE:** send 0x01 with ch = 7, which sets err_range with no cfg_we. Send 0x02 with ch = 3, rev_data2 = 1, which gives ch_en[3] = 1 in cycle 3.
- **Mid-operation reset:** drive rst_n low during WAIT. Expect all outputs at reset values next cycle, FIFO empty, and no cfg_we afterwards.
